alu_seq_server: RTL and testbench

ALU_SEQ_SERVER -- requirements
Module: alu_seq_server

---
 rtl/alu_seq_server.sv | 162 ++++++++++++++++
 tb/tb_alu_seq_server.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_server.sv
// alu_seq_server -- single-request ALU server with a valid/ready handshake on
// both the request and response sides.
//
// Only one operation is in flight at a time. Non-shift ops (and SLL with a
// zero shift amount) complete in one cycle. SLL by k>0 shifts one bit per
// cycle in EXEC unless ALU_SEQ_FAST_SHIFT_EN is defined, in which case a
// barrel shifter makes every op single-cycle and EXEC is never entered.
//
// Build macro: ALU_SEQ_FAST_SHIFT_EN (undefined by default -> iterative SLL).
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_ready   request handshake; A, B, S, carry_in captured on it
//   A, B                  operands (B[log2(WIDTH)-1:0] is the SLL amount)
//   S                     op select: ADD SUB AND OR XOR NOR SLT SLL
//   carry_in              carry input for ADD
//   rsp_valid/rsp_ready   response handshake
//   result, carry_out, zero  registered response fields, held while in DONE
module alu_seq_server #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       S,
  input  logic             carry_in,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero
);
  localparam int SW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOR = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_SLL = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic [SW-1:0]    cnt_q, cnt_d;

  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] addend;
  logic             cin_eff;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;

  // Single adder serves ADD and SUB (SUB = A + ~B + 1); SLT uses a signed
  // compare so it does not depend on adder overflow interpretation.
  always_comb begin
    shamt   = B[SW-1:0];
    addend  = (S == OP_SUB) ? ~B : B;
    cin_eff = (S == OP_SUB) ? 1'b1 : carry_in;
    sum     = {1'b0, A} + {1'b0, addend} + {{WIDTH{1'b0}}, cin_eff};
    alu_res = '0;
    alu_c   = 1'b0;
    case (S)
      OP_ADD, OP_SUB: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
      end
      OP_AND: alu_res = A & B;
      OP_OR:  alu_res = A | B;
      OP_XOR: alu_res = A ^ B;
      OP_NOR: alu_res = ~(A | B);
      OP_SLT: alu_res = ($signed(A) < $signed(B)) ? WIDTH'(1) : '0;
`ifdef ALU_SEQ_FAST_SHIFT_EN
      OP_SLL: alu_res = A << shamt;
`else
      // Only the shamt==0 case finishes here; k>0 goes through EXEC.
      OP_SLL: alu_res = A;
`endif
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
`ifndef ALU_SEQ_FAST_SHIFT_EN
          if (S == OP_SLL && shamt != '0) begin
            // First shift happens on the accept edge, so k shifts plus the
            // EXEC->DONE edge land rsp_valid k+1 edges after the request.
            state_d  = EXEC;
            result_d = A << 1;
            cnt_d    = shamt - SW'(1);
            carry_d  = 1'b0;
            zero_d   = 1'b0;
          end else
`endif
          begin
            state_d  = DONE;
            result_d = alu_res;
            carry_d  = alu_c;
            zero_d   = (alu_res == '0);
          end
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          zero_d  = (result_q == '0);
        end else begin
          result_d = result_q << 1;
          cnt_d    = cnt_q - SW'(1);
        end
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      cnt_q    <= cnt_d;
    end
  end

  // reset gates req_ready combinationally so no request is taken in a reset cycle
  assign req_ready = (state_q == IDLE) && !reset;
  assign rsp_valid = (state_q == DONE);
  assign result    = result_q;
  assign carry_out = carry_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_seq_server.sv
module tb_alu_seq_server;
  localparam int W  = 32;
  localparam int SW = 5;
`ifdef ALU_SEQ_FAST_SHIFT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid = 1'b0;
  logic         rsp_ready = 1'b0;
  logic         carry_in = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [2:0]   S = '0;
  logic         req_ready, rsp_valid, carry_out, zero;
  logic [W-1:0] result;

  alu_seq_server #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .A(A), .B(B), .S(S), .carry_in(carry_in), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .result(result), .carry_out(carry_out), .zero(zero)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [2:0] s, input logic cin,
                                 output logic [W-1:0] r, output logic c);
    logic [W:0] t;
    r = '0;
    c = 1'b0;
    case (s)
      3'd0: begin t = a + b + cin; r = t[W-1:0]; c = t[W]; end
      3'd1: begin r = a - b; c = (a >= b); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~(a | b);
      3'd6: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: r = a << b[SW-1:0];
    endcase
  endfunction

  // edges from the request cycle until rsp_valid is seen (1 = next cycle)
  function automatic int ref_lat(input logic [2:0] s, input logic [W-1:0] b);
    if (!FAST && s == 3'd7 && b[SW-1:0] != '0) return int'(b[SW-1:0]) + 1;
    return 1;
  endfunction

  bit           m_init = 0, m_valid = 0, m_known = 0;
  int           m_wait = 0, m_lat = 0;
  logic [W-1:0] m_res = '0;
  logic         m_c = 1'b0, m_z = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_init = 1; m_valid = 0; m_wait = 0; m_known = 1;
      m_res = '0; m_c = 1'b0; m_z = 1'b0;
    end else if (m_init) begin
      if (m_valid) begin
        if (rsp_ready) m_valid = 0;
      end else if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) begin m_valid = 1; m_known = 1; end
      end else if (req_valid) begin
        ref_op(A, B, S, carry_in, m_res, m_c);
        m_z = (m_res == '0);
        m_lat = ref_lat(S, B);
        if (m_lat == 1) begin m_valid = 1; m_known = 1; end
        else begin m_wait = m_lat - 1; m_known = 0; end
      end
    end
  end

  // compare process: runs every cycle, away from the clock edge
  always @(negedge clk) begin
    #2;
    if (m_init) begin
      chk("req_ready", {31'd0, req_ready}, {31'd0, (!reset && !m_valid && m_wait == 0)});
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_valid});
      if (m_known) begin
        chk("result", result, m_res);
        chk("carry_out", {31'd0, carry_out}, {31'd0, m_c});
        chk("zero", {31'd0, zero}, {31'd0, m_z});
      end
    end
  end

  // ---------------- directed transactions with literal expectations ----------------
  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] s,
                    input logic cin, input logic [W-1:0] er, input logic ec, input logic ez,
                    input int elat, input int hold, input string nm);
    int n, t;
    t = 0;
    while (!req_ready && t < 200) begin @(negedge clk); t++; end
    chk({nm, "_ready_wait"}, {31'd0, req_ready}, 32'd1);
    A = a; B = b; S = s; carry_in = cin; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    A = $urandom; B = $urandom; S = 3'($urandom); carry_in = 1'($urandom);
    n = 1;
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
    chk({nm, "_latency"}, n, elat);
    chk({nm, "_result"}, result, er);
    chk({nm, "_carry"}, {31'd0, carry_out}, {31'd0, ec});
    chk({nm, "_zero"}, {31'd0, zero}, {31'd0, ez});
    repeat (hold) begin
      rsp_ready = 1'b0;
      @(negedge clk);
      chk({nm, "_held_result"}, result, er);
      chk({nm, "_held_valid"}, {31'd0, rsp_valid}, 32'd1);
      chk({nm, "_held_ready"}, {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({nm, "_back_idle"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    int seen;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_carry", {31'd0, carry_out}, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

    op(32'd13, 32'd9, 3'd0, 1'b0, 32'd22, 1'b0, 1'b0, 1, 0, "add");
    op(32'd11, 32'd14, 3'd1, 1'b0, 32'hFFFFFFFD, 1'b0, 1'b0, 1, 0, "sub");
    op(32'hFFFFFFFF, 32'd0, 3'd0, 1'b1, 32'd0, 1'b1, 1'b1, 1, 0, "add_wrap");
    op(32'd5, 32'd5, 3'd1, 1'b0, 32'd0, 1'b1, 1'b1, 1, 0, "sub_equal");
    op(32'd9, 32'd4, 3'd7, 1'b0, 32'h90, 1'b0, 1'b0, FAST ? 1 : 5, 0, "sll4");
    op(32'd7, 32'h20, 3'd7, 1'b0, 32'd7, 1'b0, 1'b0, 1, 0, "sll0");
    op(32'd3, 32'd31, 3'd7, 1'b0, 32'h80000000, 1'b0, 1'b0, FAST ? 1 : 32, 0, "sll31");
    op(32'd2, 32'd31, 3'd7, 1'b0, 32'd0, 1'b0, 1'b1, FAST ? 1 : 32, 0, "sll_out");
    op(32'hFFFFFFFE, 32'd1, 3'd6, 1'b0, 32'd1, 1'b0, 1'b0, 1, 4, "slt_bp");
    op(32'd1, 32'hFFFFFFFE, 3'd6, 1'b0, 32'd0, 1'b0, 1'b1, 1, 0, "slt_false");
    op(32'hF0F0F0F0, 32'hFF00FF00, 3'd2, 1'b1, 32'hF000F000, 1'b0, 1'b0, 1, 0, "and");
    op(32'hF0F0F0F0, 32'hFF00FF00, 3'd3, 1'b1, 32'hFFF0FFF0, 1'b0, 1'b0, 1, 0, "or");
    op(32'hF0F0F0F0, 32'hFF00FF00, 3'd4, 1'b1, 32'h0FF00FF0, 1'b0, 1'b0, 1, 0, "xor");
    op(32'hF0F0F0F0, 32'hFF00FF00, 3'd5, 1'b1, 32'h000F000F, 1'b0, 1'b0, 1, 0, "nor");

    if (!FAST) begin
      // reset in the 3rd EXEC cycle of a long shift: op must vanish
      A = 32'd1; B = 32'd20; S = 3'd7; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("midrst_result", result, 32'd0);
      seen = 0;
      rsp_ready = 1'b1;
      repeat (40) begin
        @(negedge clk);
        if (rsp_valid) seen++;
      end
      rsp_ready = 1'b0;
      chk("midrst_no_rsp", seen, 32'd0);
    end

    // randomized traffic; all checking by the compare process
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      reset     = ($urandom_range(0, 249) == 0);
      req_valid = 1'($urandom);
      rsp_ready = ($urandom_range(0, 2) != 0);
      S         = 3'($urandom);
      carry_in  = 1'($urandom);
      case ($urandom_range(0, 3))
        0: begin A = $urandom; B = A; end
        1: begin A = '0; B = $urandom_range(0, 7); end
        default: begin A = $urandom; B = $urandom; end
      endcase
    end
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b0;
    repeat (40) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
